// File: rtl/dlsc_mt9v032_pkg.sv
// Shared definitions for the MT9V032 camera pipeline: scheduler state encoding
// and compile-time width helpers.
package dlsc_mt9v032_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_NEXT = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Never returns zero so a degenerate parameter still yields a legal vector.
    function automatic int clog2_min1(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/dlsc_mt9v032_line_mux_if.sv
// Per-camera input streams and the merged, tagged output stream of the line mux.
interface dlsc_mt9v032_line_mux_if #(
    parameter int CAMERAS = 2,
    parameter int DATA    = 10
);
    import dlsc_mt9v032_pkg::*;

    localparam int CAM_BITS = clog2_min1(CAMERAS);

    logic [CAMERAS-1:0]      in_ready;
    logic [CAMERAS-1:0]      in_valid;
    logic [CAMERAS*DATA-1:0] in_data;
    logic                    out_ready;
    logic                    out_valid;
    logic [DATA-1:0]         out_data;
    logic [CAM_BITS-1:0]     out_cam;
    logic                    out_eol;
    logic                    out_eof;

    modport master (
        output in_ready,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_cam,
        output out_eol,
        output out_eof
    );

    modport slave (
        input  in_ready,
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_cam,
        input  out_eol,
        input  out_eof
    );

endinterface

// File: rtl/dlsc_mt9v032_line_mux.sv
// Line-interleaving scheduler: grants enabled cameras in ascending order, one
// full line each, and tags every merged pixel with camera ID, EOL and EOF.
module dlsc_mt9v032_line_mux
    import dlsc_mt9v032_pkg::*;
#(
    parameter int CAMERAS = 2,
    parameter int DATA    = 10,
    parameter int HDISP   = 752,
    parameter int VDISP   = 480
) (
    input  logic                          px_clk,
    input  logic                          px_rst_n,
    input  logic [CAMERAS-1:0]            cfg_enable,
    dlsc_mt9v032_line_mux_if.master       bus,
    output logic                          busy
);

    localparam int CAM_BITS = clog2_min1(CAMERAS);
    localparam int COL_W    = clog2_min1(HDISP);
    localparam int ROW_W    = clog2_min1(VDISP);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(HDISP - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(VDISP - 1);

    state_t               state_r;
    logic [CAM_BITS-1:0]  sel_r;
    logic [COL_W-1:0]     col_r;
    logic [ROW_W-1:0]     row_r;
    logic [CAMERAS-1:0]   mask_r;

    logic                 out_valid_r;
    logic [DATA-1:0]      out_data_r;
    logic [CAM_BITS-1:0]  out_cam_r;
    logic                 out_eol_r;
    logic                 out_eof_r;

    logic [CAM_BITS-1:0]  first_cfg_s;
    logic [CAM_BITS-1:0]  first_mask_s;
    logic [CAM_BITS-1:0]  next_sel_s;
    logic                 has_next_s;
    logic                 room_s;
    logic                 adv_s;
    logic                 last_col_s;
    logic [CAMERAS-1:0]   in_ready_s;
    logic [DATA-1:0]      sel_data_s;

    // Priority search over the enable/mask vectors; scanning downward leaves the lowest hit.
    always_comb begin
        first_cfg_s  = '0;
        first_mask_s = '0;
        next_sel_s   = '0;
        has_next_s   = 1'b0;
        for (int j = CAMERAS - 1; j >= 0; j--) begin
            first_cfg_s  = cfg_enable[j] ? CAM_BITS'(j) : first_cfg_s;
            first_mask_s = mask_r[j]     ? CAM_BITS'(j) : first_mask_s;
            next_sel_s   = (mask_r[j] && (j > int'(sel_r))) ? CAM_BITS'(j) : next_sel_s;
            has_next_s   = has_next_s | (mask_r[j] && (j > int'(sel_r)));
        end
    end

    // Handshake decode for the granted camera.
    always_comb begin
        room_s     = !out_valid_r || bus.out_ready;
        adv_s      = (state_r == ST_XFER) && bus.in_valid[sel_r] && room_s;
        last_col_s = (col_r == COL_LAST);
        sel_data_s = bus.in_data[int'(sel_r)*DATA +: DATA];
        in_ready_s = '0;
        if ((state_r == ST_XFER) && room_s) begin
            in_ready_s[sel_r] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    // Scheduler FSM plus the single-stage output register.
    always_ff @(posedge px_clk) begin
        if (!px_rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= '0;
            col_r       <= '0;
            row_r       <= '0;
            mask_r      <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_cam_r   <= '0;
            out_eol_r   <= 1'b0;
            out_eof_r   <= 1'b0;
        end else begin
            if (adv_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sel_data_s;
                out_cam_r   <= sel_r;
                out_eol_r   <= last_col_s;
                out_eof_r   <= last_col_s && (row_r == ROW_LAST) && !has_next_s;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                ST_IDLE: begin
                    mask_r <= cfg_enable;
                    if (cfg_enable != '0) begin
                        sel_r   <= first_cfg_s;
                        row_r   <= '0;
                        col_r   <= '0;
                        state_r <= ST_XFER;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (adv_s && last_col_s) begin
                        col_r   <= '0;
                        state_r <= ST_NEXT;
                    end else if (adv_s) begin
                        col_r   <= col_r + COL_W'(1);
                    end else begin
                        col_r   <= col_r;
                    end
                end
                // Bubble cycle between lines: pick the next camera or wrap to the next row.
                ST_NEXT: begin
                    if (has_next_s) begin
                        sel_r   <= next_sel_s;
                        state_r <= ST_XFER;
                    end else if (row_r == ROW_LAST) begin
                        row_r   <= '0;
                        state_r <= ST_IDLE;
                    end else begin
                        sel_r   <= first_mask_s;
                        row_r   <= row_r + ROW_W'(1);
                        state_r <= ST_XFER;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_cam   = out_cam_r;
    assign bus.out_eol   = out_eol_r;
    assign bus.out_eof   = out_eof_r;
    assign busy          = (state_r != ST_IDLE);

endmodule

// File: doc/dlsc_mt9v032_line_mux.md
Name: dlsc_mt9v032_line_mux

Overview:
- Line-interleaving scheduler that merges the per-camera pixel streams into one stream on px_clk, downstream of the per-camera output FIFOs.
- Cameras are granted in strict ascending order, one full line (HDISP pixels) per grant. A stereo or multi-camera frame therefore arrives as cam0 row0, cam1 row0, ..., cam0 row1, ...
- Tags every output pixel with its camera ID, end-of-line and end-of-frame.

Parameters:
- CAMERAS, 2, number of input streams (1..16)
- DATA, 10, pixel width
- HDISP, 752, pixels per line per grant
- VDISP, 480, lines per frame per camera
- CAM_BITS, max(1,clog2(CAMERAS)), width of camera ID (derived; do not override)

Ports:
- px_clk  in  1  pixel clock
- px_rst_n  in  1  reset, synchronous, active-low
- cfg_enable  in  CAMERAS  camera enable mask; sampled only at frame boundary
- in_ready  out  CAMERAS  per-camera pop
- in_valid  in  CAMERAS  per-camera data available
- in_data  in  CAMERAS*DATA  camera j at [j*DATA +: DATA]
- out_ready  in  1  downstream accept
- out_valid  out  1  output pixel valid
- out_data  out  DATA  pixel
- out_cam  out  CAM_BITS  source camera of out_data
- out_eol  out  1  last pixel of a line
- out_eof  out  1  last pixel of the frame (last enabled camera, row VDISP-1, col HDISP-1)
- busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (px_rst_n=0 at a clock edge):
  - outputs: out_valid=0, in_ready=0, out_data=0, out_cam=0, out_eol=0, out_eof=0, busy=0
  - internal: state=IDLE, col=0, row=0, sel=0, frame mask=0
  - a line in progress is abandoned and no partial-line flush occurs. Upstream FIFOs are reset by their owner.
- States: IDLE, XFER, NEXT.
- IDLE:
  - Each cycle, latch mask <= cfg_enable.
  - If cfg_enable != 0: sel <= lowest set bit, row=0, col=0, go XFER.
  - If cfg_enable == 0: stay in IDLE.
- XFER:
  - Transfer condition is adv = in_valid[sel] && (!out_valid || out_ready).
  - in_ready[sel] = state==XFER && (!out_valid || out_ready). All other in_ready bits are 0.
  - On adv, the output register loads: data=in_data[sel], cam=sel, eol=(col==HDISP-1), eof=eol && row==VDISP-1 && sel is the highest set bit in mask. col increments.
  - On the adv with col==HDISP-1: col<=0, go NEXT.
- NEXT (one bubble cycle; no input accepted):
  - If sel is the highest set bit in mask and row==VDISP-1: row<=0, go IDLE. The frame ends; mask is re-sampled in IDLE.
  - If sel is the highest set bit in mask but row<VDISP-1: sel <= lowest set bit, row increments, go XFER.
  - Otherwise: sel <= next higher set bit, go XFER.
- Output register: single stage.
  - Holds its value while out_valid && !out_ready.
  - Clears out_valid when out_ready is high and there is no adv in that cycle.
  - Latency is 1 cycle from an input pop to out_valid.
  - Throughput is 1 pixel/cycle within a line, plus 1 bubble per line.
- Strict order: an idle or stalled granted camera stalls the whole mux. Other cameras are never skipped mid-frame, which keeps rows aligned.
- cfg_enable changes while busy are ignored until the next IDLE.
- Simultaneous out_ready with adv: the register is overwritten and no bubble is inserted.
- CAMERAS=1: sel is always 0 and out_cam is always 0. Behaviour is otherwise unchanged.
- Counter widths: col is clog2(HDISP) bits and row is clog2(VDISP) bits. Compares are against HDISP-1 and VDISP-1 exactly; counters never wrap past those values.

Decomposition:
- Shared package/include dlsc_mt9v032_pkg: state encodings (IDLE/XFER/NEXT) and the clog2 function used for CAM_BITS and counter widths.
- The find-lowest-set-bit and find-next-set-bit-above-sel logic is combinational and stays inline.
- No sub-module; the output register is small enough to keep inline.

Test Plan:
- CAMERAS=2, HDISP=4, VDISP=2, cfg_enable=2'b11, all inputs always valid, out_ready=1 -> 16 pixels ordered cam0 r0, cam1 r0, cam0 r1, cam1 r1. out_eol on pixels 4, 8, 12, 16; out_eof only on pixel 16 with out_cam=1. One bubble cycle between lines. busy falls after the last NEXT.
- Same setup, out_ready toggled randomly -> no pixel lost or duplicated. out_data/out_cam/flags stay stable while out_valid && !out_ready. The scoreboard matches the ordered stream.
- cfg_enable=2'b10 -> only camera 1 is granted, in_ready[0] is never asserted, and eof falls on cam1 r1 c3. Changing to 2'b11 mid-frame has no effect until the next frame.
- cam1 in_valid held low for 20 cycles during its grant -> the mux stalls, in_ready[0]=0 throughout, and the stream resumes with cam1 at the correct column.
- cfg_enable=0 -> stays in IDLE, busy=0, in_ready=0.
- px_rst_n pulsed low for 1 cycle mid-line (col=2, sel=1) -> the following cycle all outputs are at reset values. After re-enable, the next frame starts at cam0 r0 c0.
